// File: rtl/elevator_pkg.sv
// Shared types for the elevator bank: per-car state codes and sweep direction.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } car_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/elevator_car.sv
// One elevator car: pending-floor bitmap, SCAN sweep FSM, move and door timers.
module elevator_car
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_set,
  input  logic [FLOOR_W-1:0]    i_req_floor,
  input  logic                  i_hold,
  output logic [FLOOR_W-1:0]    o_floor,
  output logic [1:0]            o_state,
  output logic                  o_door_open,
  output logic [NUM_FLOORS-1:0] o_pending
);

  localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MCW-1:0] MOVE_LOAD = MCW'(MOVE_CYCLES - 1);
  localparam logic [DCW-1:0] DOOR_LOAD = DCW'(DOOR_CYCLES - 1);

  car_state_e            r_state, w_state;
  dir_e                  r_dir, w_dir;
  logic [FLOOR_W-1:0]    r_floor, w_floor;
  logic [MCW-1:0]        r_move_cnt, w_move_cnt;
  logic [DCW-1:0]        r_door_cnt, w_door_cnt;
  logic [NUM_FLOORS-1:0] r_pending, w_pending, w_set, w_clr;
  logic [FLOOR_W-1:0]    w_nf_up, w_nf_dn;
  logic                  w_above, w_below, w_above_up, w_below_dn, w_open_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dir      <= DIR_UP;
      r_floor    <= '0;
      r_move_cnt <= '0;
      r_door_cnt <= '0;
      r_pending  <= '0;
    end else begin
      r_state    <= w_state;
      r_dir      <= w_dir;
      r_floor    <= w_floor;
      r_move_cnt <= w_move_cnt;
      r_door_cnt <= w_door_cnt;
      r_pending  <= w_pending;
    end
  end

  always_comb begin
    w_nf_up    = r_floor + 1'b1;
    w_nf_dn    = r_floor - 1'b1;
    w_above    = 1'b0;
    w_below    = 1'b0;
    w_above_up = 1'b0;
    w_below_dn = 1'b0;
    for (int unsigned k = 0; k < NUM_FLOORS; k++) begin
      if (r_pending[k]) begin
        if (FLOOR_W'(k) > r_floor) w_above = 1'b1;
        if (FLOOR_W'(k) < r_floor) w_below = 1'b1;
        if (FLOOR_W'(k) > w_nf_up) w_above_up = 1'b1;
        if (FLOOR_W'(k) < w_nf_dn) w_below_dn = 1'b1;
      end
    end

    w_state    = r_state;
    w_dir      = r_dir;
    w_floor    = r_floor;
    w_move_cnt = r_move_cnt;
    w_door_cnt = r_door_cnt;
    w_set      = '0;
    w_clr      = '0;
    w_open_hit = i_req_set && (r_state == ST_DOOR_OPEN) && (i_req_floor == r_floor);

    case (r_state)
      ST_IDLE: begin
        if (r_pending[r_floor]) begin
          w_state          = ST_DOOR_OPEN;
          w_clr[r_floor]   = 1'b1;
          w_door_cnt       = DOOR_LOAD;
        end else if (w_above && (r_dir == DIR_UP || !w_below)) begin
          w_state    = ST_MOVE_UP;
          w_dir      = DIR_UP;
          w_move_cnt = MOVE_LOAD;
        end else if (w_below) begin
          w_state    = ST_MOVE_DOWN;
          w_dir      = DIR_DOWN;
          w_move_cnt = MOVE_LOAD;
        end
      end
      ST_MOVE_UP: begin
        if (r_move_cnt != '0) begin
          w_move_cnt = r_move_cnt - 1'b1;
        end else begin
          w_floor = w_nf_up;
          if (r_pending[w_nf_up]) begin
            w_state        = ST_DOOR_OPEN;
            w_clr[w_nf_up] = 1'b1;
            w_door_cnt     = DOOR_LOAD;
          end else if (w_above_up) begin
            w_move_cnt = MOVE_LOAD;
          end else begin
            w_state = ST_IDLE;
          end
        end
      end
      ST_MOVE_DOWN: begin
        if (r_move_cnt != '0) begin
          w_move_cnt = r_move_cnt - 1'b1;
        end else begin
          w_floor = w_nf_dn;
          if (r_pending[w_nf_dn]) begin
            w_state        = ST_DOOR_OPEN;
            w_clr[w_nf_dn] = 1'b1;
            w_door_cnt     = DOOR_LOAD;
          end else if (w_below_dn) begin
            w_move_cnt = MOVE_LOAD;
          end else begin
            w_state = ST_IDLE;
          end
        end
      end
      ST_DOOR_OPEN: begin
        if (i_hold)                  w_door_cnt = DOOR_LOAD;
        else if (r_door_cnt != '0)   w_door_cnt = r_door_cnt - 1'b1;
        else                         w_state    = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase

    // A call at the open floor re-arms the door even on the closing edge.
    if (w_open_hit) begin
      w_state    = ST_DOOR_OPEN;
      w_door_cnt = DOOR_LOAD;
    end
    if (i_req_set && !w_open_hit) w_set[i_req_floor] = 1'b1;
    w_pending = (r_pending | w_set) & ~w_clr;
  end

  always_comb begin
    o_floor     = r_floor;
    o_state     = r_state;
    o_door_open = (r_state == ST_DOOR_OPEN);
    o_pending   = r_pending;
  end

endmodule

// File: rtl/elevator_bank.sv
// N-car elevator bank: shared request decode with range check, error pulse, output packing.
module elevator_bank
  import elevator_pkg::*;
#(
  parameter int NUM_CARS    = 3,
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3,
  localparam int CAR_W      = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic [CAR_W-1:0]               req_car,
  input  logic [FLOOR_W-1:0]             req_floor,
  output logic                           req_err,
  input  logic [NUM_CARS-1:0]            car_hold,
  output logic [NUM_CARS*FLOOR_W-1:0]    car_floor,
  output logic [NUM_CARS*2-1:0]          car_state,
  output logic [NUM_CARS-1:0]            car_door_open,
  output logic [NUM_CARS*NUM_FLOORS-1:0] car_pending
);

  localparam logic [CAR_W:0]   CARS_LIM   = (CAR_W + 1)'(NUM_CARS);
  localparam logic [FLOOR_W:0] FLOORS_LIM = (FLOOR_W + 1)'(NUM_FLOORS);

  logic                w_req_ok;
  logic [NUM_CARS-1:0] w_req_set;
  logic                r_req_err;

  assign w_req_ok = ({1'b0, req_car} < CARS_LIM) && ({1'b0, req_floor} < FLOORS_LIM);

  always_ff @(posedge clk) begin
    if (rst) r_req_err <= 1'b0;
    else     r_req_err <= req_valid && !w_req_ok;
  end
  assign req_err = r_req_err;

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    assign w_req_set[g] = req_valid && w_req_ok && (req_car == CAR_W'(g));

    elevator_car #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W),
      .MOVE_CYCLES(MOVE_CYCLES),
      .DOOR_CYCLES(DOOR_CYCLES)
    ) u_car (
      .clk        (clk),
      .rst        (rst),
      .i_req_set  (w_req_set[g]),
      .i_req_floor(req_floor),
      .i_hold     (car_hold[g]),
      .o_floor    (car_floor[g*FLOOR_W +: FLOOR_W]),
      .o_state    (car_state[g*2 +: 2]),
      .o_door_open(car_door_open[g]),
      .o_pending  (car_pending[g*NUM_FLOORS +: NUM_FLOORS])
    );
  end

endmodule

// File: tb/tb_elevator_bank.sv
// Self-checking bench for elevator_bank: decode vectors, trip timing, SCAN, hold, reset, concurrency.
module tb_elevator_bank;

  localparam int NC = 3;
  localparam int NF = 7;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [1:0]    req_car;
  logic [FW-1:0] req_floor;
  logic          req_err;
  logic [NC-1:0] car_hold;
  logic [NC*FW-1:0] car_floor;
  logic [NC*2-1:0]  car_state;
  logic [NC-1:0]    car_door_open;
  logic [NC*NF-1:0] car_pending;

  elevator_bank #(
    .NUM_CARS   (NC),
    .NUM_FLOORS (NF),
    .MOVE_CYCLES(4),
    .DOOR_CYCLES(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_car      (req_car),
    .req_floor    (req_floor),
    .req_err      (req_err),
    .car_hold     (car_hold),
    .car_floor    (car_floor),
    .car_state    (car_state),
    .car_door_open(car_door_open),
    .car_pending  (car_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [1:0] car;
    logic [2:0] floor;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic           err;
    logic [NC*NF-1:0] pend;
  } dec_exp_t;

  typedef struct {
    logic [FW-1:0] floor;
    logic [1:0]    state;
    logic          door;
    logic          pend;
  } trip_exp_t;

  vec_t      vecs[8];
  dec_exp_t  dec_q[$];
  trip_exp_t trip_q[$];
  int        n_assert = 0;
  int        n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] fl(input int c);
    return car_floor[c*FW +: FW];
  endfunction

  function automatic logic [1:0] st(input int c);
    return car_state[c*2 +: 2];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_floor"}, 64'(car_floor), 64'd0);
    check({tag, "_state"}, 64'(car_state), 64'd0);
    check({tag, "_pend"},  64'(car_pending), 64'd0);
    check({tag, "_door"},  64'(car_door_open), 64'd0);
    check({tag, "_err"},   64'(req_err), 64'd0);
  endtask

  initial begin
    logic [NC*NF-1:0] exp_pend;
    dec_exp_t  de;
    trip_exp_t te;
    logic [FW-1:0] doors[$];
    logic prev_door;
    bit sent, done;

    rst = 1'b0; req_valid = 1'b0; req_car = '0; req_floor = '0; car_hold = '0;
    vecs[0] = '{1'b1, 2'd0, 3'd3, 1'b0};
    vecs[1] = '{1'b1, 2'd3, 3'd2, 1'b1};
    vecs[2] = '{1'b1, 2'd1, 3'd7, 1'b1};
    vecs[3] = '{1'b0, 2'd3, 3'd7, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 3'd5, 1'b0};
    vecs[5] = '{1'b1, 2'd0, 3'd3, 1'b0};
    vecs[6] = '{1'b1, 2'd1, 3'd6, 1'b0};
    vecs[7] = '{1'b1, 2'd2, 3'd4, 1'b0};

    do_reset();
    check_reset_state("rst0");

    // Request decode / range check vectors
    exp_pend = '0;
    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].valid; req_car = vecs[i].car; req_floor = vecs[i].floor;
      if (vecs[i].valid && !vecs[i].exp_err)
        exp_pend[int'(vecs[i].car)*NF + int'(vecs[i].floor)] = 1'b1;
      dec_q.push_back('{vecs[i].exp_err, exp_pend});
      tick();
      de = dec_q.pop_front();
      check($sformatf("vec%0d_err", i), 64'(req_err), 64'(de.err));
      check($sformatf("vec%0d_pend", i), 64'(car_pending), 64'(de.pend));
    end
    req_valid = 1'b0;
    tick();
    check("err_one_cycle", 64'(req_err), 64'd0);

    // Reset mid-move: car 0 heading to floor 5, reset at E+6
    do_reset();
    req_valid = 1'b1; req_car = 2'd0; req_floor = 3'd5;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    check("midmove_floor", 64'(fl(0)), 64'd1);
    check("midmove_state", 64'(st(0)), 64'd1);
    rst = 1'b1; req_valid = 1'b1; req_car = 2'd1; req_floor = 3'd4;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    check_reset_state("rstmid");
    tick();
    check("rstmid_pend_after", 64'(car_pending), 64'd0);

    // Single trip latency: car 0 from floor 0 to floor 3
    req_valid = 1'b1; req_car = 2'd0; req_floor = 3'd3;
    for (int t = 0; t <= 16; t++) begin
      te.floor = (t >= 13) ? 3'd3 : (t >= 9) ? 3'd2 : (t >= 5) ? 3'd1 : 3'd0;
      te.state = (t == 0 || t == 16) ? 2'd0 : (t < 13) ? 2'd1 : 2'd3;
      te.door  = (t >= 13 && t < 16);
      te.pend  = (t < 13);
      trip_q.push_back(te);
      tick();
      req_valid = 1'b0;
      te = trip_q.pop_front();
      check($sformatf("trip_floor_t%0d", t), 64'(fl(0)), 64'(te.floor));
      check($sformatf("trip_state_t%0d", t), 64'(st(0)), 64'(te.state));
      check($sformatf("trip_door_t%0d", t), 64'(car_door_open[0]), 64'(te.door));
      check($sformatf("trip_pend_t%0d", t), 64'(car_pending[3]), 64'(te.pend));
    end

    // SCAN ordering on car 1: 6, 2, then 1 once at floor 3
    req_valid = 1'b1; req_car = 2'd1; req_floor = 3'd6;
    tick();
    req_floor = 3'd2;
    tick();
    req_valid = 1'b0;
    prev_door = car_door_open[1];
    sent = 0;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (fl(1) == 3'd3 && !sent) begin
        req_valid = 1'b1; req_car = 2'd1; req_floor = 3'd1; sent = 1;
      end
      tick();
      req_valid = 1'b0;
      if (car_door_open[1] && !prev_door) doors.push_back(fl(1));
      prev_door = car_door_open[1];
      if (doors.size() == 3) done = 1;
    end
    check("scan_door_count", 64'(doors.size()), 64'd3);
    while (doors.size() < 3) doors.push_back('1);
    check("scan_door0", 64'(doors[0]), 64'd2);
    check("scan_door1", 64'(doors[1]), 64'd6);
    check("scan_door2", 64'(doors[2]), 64'd1);

    // Door hold on car 2 at floor 0
    req_valid = 1'b1; req_car = 2'd2; req_floor = 3'd0;
    tick();
    req_valid = 1'b0;
    tick();
    check("hold_open0", 64'(car_door_open[2]), 64'd1);
    car_hold[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold_open_h%0d", i), 64'(car_door_open[2]), 64'd1);
    end
    car_hold[2] = 1'b0;
    tick();
    check("hold_rel1", 64'(car_door_open[2]), 64'd1);
    tick();
    check("hold_rel2", 64'(car_door_open[2]), 64'd1);
    tick();
    check("hold_rel3_closed", 64'(car_door_open[2]), 64'd0);
    check("hold_rel3_state", 64'(st(2)), 64'd0);

    // Call at the open floor reloads the door instead of setting the bit
    req_valid = 1'b1; req_car = 2'd2; req_floor = 3'd0;
    tick();
    req_valid = 1'b0;
    tick();
    check("openreq_door", 64'(car_door_open[2]), 64'd1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("openreq_pend", 64'(car_pending[2*NF +: NF]), 64'd0);
    tick();
    tick();
    check("openreq_still_open", 64'(car_door_open[2]), 64'd1);
    tick();
    check("openreq_closed", 64'(car_door_open[2]), 64'd0);

    // Concurrent cars
    do_reset();
    exp_pend = '0;
    for (int c = 0; c < NC; c++) begin
      req_valid = 1'b1; req_car = 2'(c);
      req_floor = (c == 0) ? 3'd2 : (c == 1) ? 3'd4 : 3'd1;
      exp_pend[c*NF + int'(req_floor)] = 1'b1;
      tick();
      check($sformatf("conc_pend%0d", c), 64'(car_pending), 64'(exp_pend));
    end
    req_valid = 1'b0;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      if (car_pending == '0 && car_state == '0) done = 1;
    end
    check("conc_settled", 64'(done), 64'd1);
    check("conc_floors", 64'(car_floor), 64'({3'd1, 3'd4, 3'd2}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
